uart_port_arbiter: RTL and testbench

- Sequences the shared UART core's byte-level ports (write strobe/data with TX-full flag; read strobe/data with RX-empty flag) and shares them between NREQ transmit requesters.
- TX side: round-robin arbiter with message locking, so multi-byte messages from one requester are never interleaved with bytes from another.
- RX side: drains the UART receive FIFO into a single valid/ready output register.
- Sits between the UART top level and the system-side producers and consumer.

---
 rtl/uart_port_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_arbiter.sv
// rtl/uart_port_arbiter.sv - shares the UART byte ports between NREQ transmit requesters and drains RX
// TX: round-robin arbitration with per-message locking and a stall timeout; RX: FWFT pop into a valid/ready register.
module uart_port_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 8,
  parameter int LOCK_TIMEOUT = 1023,
  parameter int GW           = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               uart_wr,
  output logic [DW-1:0]      uart_wdata,
  input  logic               uart_txfull,
  output logic               uart_rd,
  input  logic [DW-1:0]      uart_rdata,
  input  logic               uart_rxempty,
  output logic               rx_valid,
  output logic [DW-1:0]      rx_data,
  input  logic               rx_ready,
  output logic [GW-1:0]      grant_id,
  output logic               tx_busy,
  output logic               err_timeout
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [CW-1:0]   r_cnt;
  logic            r_err_timeout;
  logic            r_rx_valid;
  logic [DW-1:0]   r_rx_data;

  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [GW-1:0]   w_next_ptr;
  logic [NREQ-1:0] w_ready;
  logic            w_xfer;
  logic            w_rd;

  // First requesting index at or after the round-robin pointer, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_pick  = GW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  assign w_next_ptr = (r_grant_id == GW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_ready = '0;
    if (r_state == ST_LOCK && !uart_txfull)
      w_ready[r_grant_id] = 1'b1;
  end

  assign w_xfer     = |(w_ready & req_valid);
  assign req_ready  = w_ready;
  assign uart_wr    = w_xfer;
  assign uart_wdata = req_data[int'(r_grant_id)*DW +: DW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_cnt         <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_cnt      <= '0;
            r_state    <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_xfer) begin
            r_cnt <= '0;
            if (req_last[r_grant_id]) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            // This is the LOCK_TIMEOUT-th idle cycle: abandon the partial message.
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
            r_rr_ptr      <= w_next_ptr;
            r_cnt         <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_id    = r_grant_id;
  assign tx_busy     = (r_state == ST_LOCK);
  assign err_timeout = r_err_timeout;

  // Pop only when the output register is free or being emptied this cycle.
  assign w_rd    = rstn && !uart_rxempty && (!r_rx_valid || rx_ready);
  assign uart_rd = w_rd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else if (w_rd) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= uart_rdata;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// tb/tb_uart_port_arbiter.sv - directed bench for uart_port_arbiter with a looped-back UART FIFO model
module tb_uart_port_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        uart_wr;
  logic [7:0]  uart_wdata;
  logic        uart_txfull;
  logic        uart_rd;
  logic [7:0]  uart_rdata;
  logic        uart_rxempty;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [1:0]  grant_id;
  logic        tx_busy;
  logic        err_timeout;

  int errors;
  int checks;

  logic       loop_en;
  logic [7:0] fifo_mem [16];
  int         wp;
  int         rp;

  uart_port_arbiter #(.NREQ(4), .DW(8), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_wr(uart_wr), .uart_wdata(uart_wdata), .uart_txfull(uart_txfull),
    .uart_rd(uart_rd), .uart_rdata(uart_rdata), .uart_rxempty(uart_rxempty),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .grant_id(grant_id), .tx_busy(tx_busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART FIFO stand-in: first-word fall-through, optionally fed by the TX side.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (uart_rd) rp <= rp + 1;
      if (loop_en && uart_wr) begin
        fifo_mem[wp % 16] <= uart_wdata;
        wp <= wp + 1;
      end
    end
  end
  assign uart_rxempty = (wp == rp);
  assign uart_rdata   = fifo_mem[rp % 16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]      = v;
    req_data[i*8 +: 8] = d;
    req_last[i]       = l;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", grant_id); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_timeout); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b expected 0", uart_wr); end
    tick();
    rstn = 1'b1;
    loop_en = 1'b1;
    set_req(2, 1'b1, 8'h22, 1'b0);
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL arb_latency: got busy=%b expected 0", tx_busy); end
    tick();
    @(negedge clk);
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL lock_grant2: got %0d expected 2", grant_id); end
    checks++; if (uart_wr !== 1'b1) begin errors++; $display("FAIL lock_wr2: got %b expected 1", uart_wr); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_rx: got %b expected 1", rx_valid); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL midrst_wr: got %b expected 0", uart_wr); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
    checks++; if (uart_rd !== 1'b0) begin errors++; $display("FAIL midrst_rd: got %b expected 0", uart_rd); end
    req_valid = '0;
    req_last  = '0;
    loop_en   = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL postrst_busy: got %b expected 0", tx_busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL postrst_grant: got %0d expected 0", grant_id); end
    tick();
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h10 + 8'(i);
      set_req(i, 1'b1, exp_d, 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      exp_d = 8'h10 + 8'(k % 4);
      @(negedge clk);
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got wr=%b expected 0", k, uart_wr); end
      tick();
      @(negedge clk);
      checks++; if (uart_wr !== 1'b1) begin errors++; $display("FAIL rr_wr%0d: got %b expected 1", k, uart_wr); end
      checks++; if (grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, grant_id, k % 4); end
      checks++; if (uart_wdata !== exp_d) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, uart_wdata, exp_d); end
      tick();
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_lock;
    logic [7:0] msg [3];
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
    set_req(0, 1'b1, 8'h55, 1'b1);
    for (int j = 0; j < 3; j++) begin
      set_req(1, 1'b1, msg[j], (j == 2));
      if (j == 0) begin
        @(negedge clk);
        checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL lock_arb: got wr=%b expected 0", uart_wr); end
        tick();
      end
      @(negedge clk);
      checks++; if (uart_wr !== 1'b1 || uart_wdata !== msg[j]) begin errors++; $display("FAIL lock_byte%0d: got wr=%b data=%h expected wr=1 data=%h", j, uart_wr, uart_wdata, msg[j]); end
      checks++; if (grant_id !== 2'd1 || req_ready[0] !== 1'b0) begin errors++; $display("FAIL lock_owner%0d: got grant=%0d ready0=%b expected 1,0", j, grant_id, req_ready[0]); end
      tick();
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL lock_gap: got wr=%b expected 0", uart_wr); end
    tick();
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h55 || grant_id !== 2'd0) begin errors++; $display("FAIL lock_next: got wr=%b data=%h grant=%0d expected 1,55,0", uart_wr, uart_wdata, grant_id); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_backpressure;
    set_req(3, 1'b1, 8'h71, 1'b0);
    tick();
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h71) begin errors++; $display("FAIL bp_first: got wr=%b data=%h expected 1,71", uart_wr, uart_wdata); end
    tick();
    set_req(3, 1'b1, 8'h72, 1'b0);
    uart_txfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (uart_wr !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL bp_stall%0d: got wr=%b ready=%b expected 0,0000", s, uart_wr, req_ready); end
      tick();
    end
    uart_txfull = 1'b0;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h72) begin errors++; $display("FAIL bp_resume: got wr=%b data=%h expected 1,72", uart_wr, uart_wdata); end
    tick();
    set_req(3, 1'b1, 8'h73, 1'b1);
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h73) begin errors++; $display("FAIL bp_last: got wr=%b data=%h expected 1,73", uart_wr, uart_wdata); end
    tick();
    set_req(3, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if (uart_wr !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL bp_done: got wr=%b busy=%b expected 0,0", uart_wr, tx_busy); end
  endtask

  task automatic test_timeout;
    int idle;
    logic seen;
    idle = 0;
    seen = 1'b0;
    tick();
    set_req(1, 1'b1, 8'h61, 1'b0);
    set_req(2, 1'b1, 8'h62, 1'b1);
    tick();
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h61 || grant_id !== 2'd1) begin errors++; $display("FAIL to_start: got wr=%b data=%h grant=%0d expected 1,61,1", uart_wr, uart_wdata, grant_id); end
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (tx_busy === 1'b1 && uart_wr === 1'b0) idle++;
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_pulse: got none within 40 cycles expected pulse"); end
    checks++; if (idle != 16) begin errors++; $display("FAIL to_idle_count: got %0d expected 16", idle); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL to_release: got busy=%b expected 0", tx_busy); end
    tick();
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", err_timeout); end
    checks++; if (grant_id !== 2'd2 || tx_busy !== 1'b1) begin errors++; $display("FAIL to_next_grant: got grant=%0d busy=%b expected 2,1", grant_id, tx_busy); end
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h62) begin errors++; $display("FAIL to_next_data: got wr=%b data=%h expected 1,62", uart_wr, uart_wdata); end
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_rx_drain;
    loop_en  = 1'b1;
    rx_ready = 1'b0;
    set_req(0, 1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'hA5) begin errors++; $display("FAIL rx_tx_a5: got wr=%b data=%h expected 1,a5", uart_wr, uart_wdata); end
    tick();
    set_req(0, 1'b1, 8'h3C, 1'b1);
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_wdata !== 8'h3C) begin errors++; $display("FAIL rx_tx_3c: got wr=%b data=%h expected 1,3c", uart_wr, uart_wdata); end
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || uart_rd !== 1'b0) begin errors++; $display("FAIL rx_hold%0d: got valid=%b data=%h rd=%b expected 1,a5,0", s, rx_valid, rx_data, uart_rd); end
      tick();
    end
    rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (uart_rd !== 1'b1) begin errors++; $display("FAIL rx_reload_rd: got %b expected 1", uart_rd); end
    tick();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL rx_second: got valid=%b data=%h expected 1,3c", rx_valid, rx_data); end
    checks++; if (uart_rxempty !== 1'b1 || uart_rd !== 1'b0) begin errors++; $display("FAIL rx_empty_rd: got empty=%b rd=%b expected 1,0", uart_rxempty, uart_rd); end
    tick();
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_drained: got valid=%b expected 0", rx_valid); end
    tick();
    rx_ready = 1'b0;
    loop_en  = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rstn        = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    uart_txfull = 1'b0;
    rx_ready    = 1'b0;
    loop_en     = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_timeout();
    test_rx_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
